// File: rtl/cpu_log_checker.sv
// Streaming checker for CPU trace records of the form ^time@pc: $grf <= data# or ^time@pc: *addr <= data#.
// One ASCII character is parsed per clock; each completed record is flagged for one cycle and counted.
module cpu_log_checker #(
   parameter int          TIME_DIGITS = 4,
   parameter int          GRF_DIGITS  = 4,
   parameter int          HEX_DIGITS  = 8,
   parameter logic [31:0] PC_LO       = 32'h0000_3000,
   parameter logic [31:0] PC_HI       = 32'h0000_4fff,
   parameter logic [31:0] ADDR_LO     = 32'h0000_0000,
   parameter logic [31:0] ADDR_HI     = 32'h0000_2fff,
   parameter int          CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       char,
   input  logic [15:0]      freq,
   output logic [1:0]       format_type,
   output logic [3:0]       error_code,
   output logic [CNT_W-1:0] rec_count,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [3:0] {
      IDLE, TIME, PC, COLON, SP1, GRF, ADDR, SP2, LT, EQ, DATA, HASH, DONE
   } state_t;

   localparam logic [7:0] TD = 8'(TIME_DIGITS);
   localparam logic [7:0] GD = 8'(GRF_DIGITS);
   localparam logic [7:0] HD = 8'(HEX_DIGITS);

   state_t           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [31:0]      time_q, time_d;
   logic [31:0]      grf_q, grf_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      addr_q, addr_d;
   logic             mem_q, mem_d;
   logic [CNT_W-1:0] rec_q, err_q;
   logic [3:0]       rec_err;

   function automatic logic is_dig(input logic [7:0] c);
      return (c >= "0") && (c <= "9");
   endfunction

   function automatic logic is_hex(input logic [7:0] c);
      return is_dig(c) || ((c >= "a") && (c <= "f"));
   endfunction

   // Low nibble of '0'-'9' is the value; 'a'-'f' low nibble is 1..6, so add 9.
   function automatic logic [3:0] nib(input logic [7:0] c);
      return is_dig(c) ? c[3:0] : c[3:0] + 4'd9;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         time_q  <= '0;
         grf_q   <= '0;
         pc_q    <= '0;
         addr_q  <= '0;
         mem_q   <= 1'b0;
         rec_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         time_q  <= time_d;
         grf_q   <= grf_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         mem_q   <= mem_d;
         // Accumulators are stable on the '#' clock, so rec_err already describes the finished record.
         if (state_d == DONE) begin
            if (rec_q != '1) rec_q <= rec_q + 1'b1;
            if ((rec_err != 4'd0) && (err_q != '1)) err_q <= err_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      time_d  = time_q;
      grf_d   = grf_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      mem_d   = mem_q;
      if (char == "^") begin
         state_d = TIME;
         cnt_d   = '0;
         time_d  = '0;
         grf_d   = '0;
         pc_d    = '0;
         addr_d  = '0;
         mem_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: state_d = IDLE;
            TIME: begin
               if (is_dig(char) && (cnt_q < TD)) begin
                  time_d = time_q * 32'd10 + {28'd0, nib(char)};
                  cnt_d  = cnt_q + 8'd1;
               end else if ((char == "@") && (cnt_q != 8'd0)) begin
                  state_d = PC;
                  cnt_d   = '0;
               end else state_d = IDLE;
            end
            PC: begin
               if (is_hex(char) && (cnt_q < HD)) begin
                  pc_d  = {pc_q[27:0], nib(char)};
                  cnt_d = cnt_q + 8'd1;
               end else if ((char == ":") && (cnt_q == HD)) state_d = COLON;
               else state_d = IDLE;
            end
            COLON, SP1: begin
               cnt_d = '0;
               if (char == " ") state_d = SP1;
               else if (char == "$") begin
                  state_d = GRF;
                  mem_d   = 1'b0;
               end else if (char == "*") begin
                  state_d = ADDR;
                  mem_d   = 1'b1;
               end else state_d = IDLE;
            end
            GRF: begin
               if (is_dig(char) && (cnt_q < GD)) begin
                  grf_d = grf_q * 32'd10 + {28'd0, nib(char)};
                  cnt_d = cnt_q + 8'd1;
               end else if ((char == " ") && (cnt_q != 8'd0)) state_d = SP2;
               else if ((char == "<") && (cnt_q != 8'd0)) state_d = LT;
               else state_d = IDLE;
            end
            ADDR: begin
               if (is_hex(char) && (cnt_q < HD)) begin
                  addr_d = {addr_q[27:0], nib(char)};
                  cnt_d  = cnt_q + 8'd1;
               end else if ((char == " ") && (cnt_q == HD)) state_d = SP2;
               else if ((char == "<") && (cnt_q == HD)) state_d = LT;
               else state_d = IDLE;
            end
            SP2: begin
               if (char == "<") state_d = LT;
               else if (char != " ") state_d = IDLE;
            end
            LT: state_d = (char == "=") ? EQ : IDLE;
            EQ: begin
               if (is_hex(char)) begin
                  cnt_d   = 8'd1;
                  state_d = (HD == 8'd1) ? HASH : DATA;
               end else if (char != " ") state_d = IDLE;
            end
            // Data digits are only counted; the value itself is never needed.
            DATA: begin
               if (is_hex(char)) begin
                  cnt_d   = cnt_q + 8'd1;
                  state_d = ((cnt_q + 8'd1) == HD) ? HASH : DATA;
               end else state_d = IDLE;
            end
            HASH: state_d = (char == "#") ? DONE : IDLE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      rec_err    = 4'd0;
      rec_err[0] = (time_q & ((32'(freq) >> 1) - 32'd1)) != 32'd0;
      rec_err[1] = (pc_q < PC_LO) || (pc_q > PC_HI) || (pc_q[1:0] != 2'd0);
      rec_err[2] = mem_q && ((addr_q < ADDR_LO) || (addr_q > ADDR_HI) || (addr_q[1:0] != 2'd0));
      rec_err[3] = !mem_q && (grf_q > 32'd31);
   end

   always_comb begin
      format_type = 2'd0;
      error_code  = 4'd0;
      if (state_q == DONE) begin
         format_type = mem_q ? 2'd2 : 2'd1;
         error_code  = rec_err;
      end
   end

   assign rec_count = rec_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_cpu_log_checker.sv
// Directed bench for cpu_log_checker: a table of trace lines with hand-computed
// record type and error flags, plus sequences for back-to-back records and mid-record reset.
module tb_cpu_log_checker;

   logic        clk;
   logic        reset;
   logic [7:0]  char;
   logic [15:0] freq;
   logic [1:0]  format_type;
   logic [3:0]  error_code;
   logic [15:0] rec_count;
   logic [15:0] err_count;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_rec = 0;
   int exp_errc = 0;

   cpu_log_checker dut (
      .clk        (clk),
      .reset      (reset),
      .char       (char),
      .freq       (freq),
      .format_type(format_type),
      .error_code (error_code),
      .rec_count  (rec_count),
      .err_count  (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       text;
      logic [15:0] fq;
      logic [1:0]  ft;
      logic [3:0]  ec;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drives one character per cycle starting at a falling edge; returns at the falling
   // edge after the last character has been sampled.
   task automatic feed(input string s);
      for (int i = 0; i < s.len(); i++) begin
         char = s[i];
         @(negedge clk);
      end
   endtask

   task automatic check_rec(input string name, input logic [1:0] ft, input logic [3:0] ec);
      if (ft != 2'd0) begin
         exp_rec++;
         if (ec != 4'd0) exp_errc++;
      end
      chk({name, " type"}, int'(format_type), int'(ft));
      chk({name, " err"}, int'(error_code), int'(ec));
      chk({name, " rec_count"}, int'(rec_count), exp_rec);
      chk({name, " err_count"}, int'(err_count), exp_errc);
   endtask

   task automatic check_gone(input string name);
      char = " ";
      @(negedge clk);
      chk({name, " one-cycle type"}, int'(format_type), 0);
      chk({name, " one-cycle err"}, int'(error_code), 0);
   endtask

   initial begin
      vecs.push_back('{"^10@00003000: $1 <= 0000000a#",       16'd4,  2'd1, 4'b0000});
      vecs.push_back('{"^3@00003002:*00003000<=00000001#",     16'd4,  2'd2, 4'b0111});
      vecs.push_back('{"^0@00003000: $32 <=00000000#",         16'd4,  2'd1, 4'b1000});
      vecs.push_back('{"^0@00003000: $12345 <=00000000#",      16'd4,  2'd0, 4'b0000});
      vecs.push_back('{"^12345@00003000: $1<=00000000#",       16'd4,  2'd0, 4'b0000});
      vecs.push_back('{"^1@0000300^2@00003004: $0<=00000000#", 16'd4,  2'd1, 4'b0000});
      vecs.push_back('{"^8@00003000:$5<=00000000#",            16'd16, 2'd1, 4'b0000});
      vecs.push_back('{"^12@00004ffc:*00002ffc <= deadbeef#",  16'd16, 2'd2, 4'b0001});
      vecs.push_back('{"^0@00005000:$31<=00000000#",           16'd4,  2'd1, 4'b0010});
      vecs.push_back('{"^0@00003000:*00000001<=00000000#",     16'd4,  2'd2, 4'b0100});
      vecs.push_back('{"^0@0000300A:$1<=00000000#",            16'd4,  2'd0, 4'b0000});
      vecs.push_back('{"^0@0003000:$1<=00000000#",             16'd4,  2'd0, 4'b0000});
      vecs.push_back('{"^0@00003000:$1<=000000000#",           16'd4,  2'd0, 4'b0000});
      vecs.push_back('{"^@00003000:$1<=00000000#",             16'd4,  2'd0, 4'b0000});
      vecs.push_back('{"^7@00003000:$1<=00000000#",            16'd2,  2'd1, 4'b0000});
      vecs.push_back('{"^0@00002ffc:*00000000<=00000000#",     16'd4,  2'd2, 4'b0010});
      vecs.push_back('{"^5@00003000:$1<=00000000#",            16'd8,  2'd1, 4'b0001});

      reset = 1'b1;
      char  = " ";
      freq  = 16'd4;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("reset type", int'(format_type), 0);
      chk("reset err", int'(error_code), 0);
      chk("reset rec_count", int'(rec_count), 0);
      chk("reset err_count", int'(err_count), 0);

      for (int i = 0; i < vecs.size(); i++) begin
         freq = vecs[i].fq;
         feed(vecs[i].text);
         check_rec($sformatf("vec%0d", i), vecs[i].ft, vecs[i].ec);
         check_gone($sformatf("vec%0d", i));
      end

      // Back-to-back records: the second '^' is sampled on the clock after '#'.
      freq = 16'd4;
      feed("^4@00003008:$2<=00000000#");
      check_rec("b2b first", 2'd1, 4'b0000);
      feed("^6@00003010:*00000010 <= 0000ffff#");
      check_rec("b2b second", 2'd2, 4'b0000);
      feed("^0@00003000:*0000000C<=00000000#");
      check_rec("b2b upper", 2'd0, 4'b0000);
      check_gone("b2b upper");

      // Reset mid-record: counters clear, the rest of the record must not report.
      feed("^5@000030");
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_rec  = 0;
      exp_errc = 0;
      chk("midreset rec_count", int'(rec_count), 0);
      chk("midreset err_count", int'(err_count), 0);
      feed("00:$1<=00000000#");
      check_rec("midreset tail", 2'd0, 4'b0000);
      feed("^2@00003000:$3<=00000000#");
      check_rec("after reset", 2'd1, 4'b0000);
      check_gone("after reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
